// File: rtl/shift_seq_ctrl.sv
// ============================================================================
// Module   : shift_seq_ctrl
// Purpose  : Sequential lsl/lsr/asr/ror unit, one amount bit per cycle,
//            with carry and zero flags and valid/ready handshakes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [1:0] c_OP_LSL = 2'd0;
    localparam logic [1:0] c_OP_LSR = 2'd1;
    localparam logic [1:0] c_OP_ASR = 2'd2;

    localparam logic [SHW-1:0] c_LAST_STAGE = SHW'(SHW - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [SHW-1:0]   r_k;
    logic [1:0]       r_op;
    logic [SHW-1:0]   r_amt;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_carry;
    logic             r_out_zero;

    logic             w_accept;
    logic             w_last;
    logic [SHW-1:0]   w_sh;
    logic [SHW-1:0]   w_lo_idx;
    logic [SHW-1:0]   w_hi_idx;
    logic [WIDTH-1:0] w_stage_acc;
    logic             w_stage_carry;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_carry_nxt;

    assign w_accept = in_valid && (r_state == c_IDLE) && !abort;
    assign w_last   = (r_k == c_LAST_STAGE);

    // Single shift-by-2^k stage; WIDTH is a power of two, so WIDTH-2^k
    // is simply the two's complement of 2^k in SHW bits.
    always_comb begin
        w_sh          = SHW'(1) << r_k;
        w_lo_idx      = w_sh - SHW'(1);
        w_hi_idx      = SHW'(0) - w_sh;
        w_stage_acc   = r_acc;
        w_stage_carry = r_carry;
        case (r_op)
            c_OP_LSL: begin
                w_stage_acc   = r_acc << w_sh;
                w_stage_carry = r_acc[w_hi_idx];
            end
            c_OP_LSR: begin
                w_stage_acc   = r_acc >> w_sh;
                w_stage_carry = r_acc[w_lo_idx];
            end
            c_OP_ASR: begin
                w_stage_acc   = $signed(r_acc) >>> w_sh;
                w_stage_carry = r_acc[w_lo_idx];
            end
            default: begin
                w_stage_acc   = (r_acc >> w_sh) | (r_acc << w_hi_idx);
                w_stage_carry = r_acc[w_lo_idx];
            end
        endcase
        w_acc_nxt   = r_amt[0] ? w_stage_acc   : r_acc;
        w_carry_nxt = r_amt[0] ? w_stage_carry : r_carry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) w_state_nxt = c_SHIFT;
            end
            c_SHIFT: begin
                if (abort)       w_state_nxt = c_IDLE;
                else if (w_last) w_state_nxt = c_DONE;
            end
            c_DONE: begin
                if (abort || out_ready) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        busy      = (r_state != c_IDLE);
        out_valid = (r_state == c_DONE);
    end

    // The amount register shifts right each stage so bit 0 is always the
    // bit for the current stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k         <= '0;
            r_op        <= '0;
            r_amt       <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_out_data  <= '0;
            r_out_carry <= 1'b0;
            r_out_zero  <= 1'b0;
        end else if (w_accept) begin
            r_k     <= '0;
            r_op    <= in_op;
            r_amt   <= in_amt;
            r_acc   <= in_data;
            r_carry <= 1'b0;
        end else if (r_state == c_SHIFT && !abort) begin
            r_k     <= r_k + SHW'(1);
            r_amt   <= r_amt >> 1;
            r_acc   <= w_acc_nxt;
            r_carry <= w_carry_nxt;
            if (w_last) begin
                r_out_data  <= w_acc_nxt;
                r_out_carry <= w_carry_nxt;
                r_out_zero  <= (w_acc_nxt == '0);
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_carry = r_out_carry;
    assign out_zero  = r_out_zero;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
// ============================================================================
// Module   : tb_shift_seq_ctrl
// Purpose  : Scoreboard bench for shift_seq_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_seq_ctrl;

    localparam int WIDTH   = 32;
    localparam int SHW     = 5;
    localparam int LAT     = SHW;
    localparam int MAXWAIT = 20;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             zero;
    } exp_t;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   a;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    shift_seq_ctrl #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-amount reference: one shift, carry = last bit moved out.
    function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] d,
                                   input logic [SHW-1:0] amt);
        exp_t                    e;
        int                      a;
        logic signed [WIDTH-1:0] sd;
        a  = int'(amt);
        sd = d;
        e.carry = 1'b0;
        case (op)
            2'd0: begin
                e.data = d << a;
                if (a != 0) e.carry = d[WIDTH-a];
            end
            2'd1: begin
                e.data = d >> a;
                if (a != 0) e.carry = d[a-1];
            end
            2'd2: begin
                e.data = sd >>> a;
                if (a != 0) e.carry = d[a-1];
            end
            default: begin
                e.data = (a == 0) ? d : ((d >> a) | (d << (WIDTH - a)));
                if (a != 0) e.carry = e.data[WIDTH-1];
            end
        endcase
        e.zero = (e.data == '0);
        return e;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] d,
                         input logic [SHW-1:0] a);
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(op, d, a));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < MAXWAIT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_data   = '0;
        in_amt    = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({out_valid, out_data, out_carry, out_zero, in_ready, busy} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h c=%b z=%b rdy=%b busy=%b, want v=0 d=0 c=0 z=0 rdy=1 busy=0",
                     out_valid, out_data, out_carry, out_zero, in_ready, busy);
        end
    endtask

    task automatic test_shift_table();
        vec_t v[$];
        exp_t e;
        int   lat;
        v.push_back('{2'd0, 32'h0000_0001, 5'd4});
        v.push_back('{2'd0, 32'hFFFF_FFFF, 5'd31});
        v.push_back('{2'd1, 32'h8000_0001, 5'd1});
        v.push_back('{2'd2, 32'h8000_0000, 5'd4});
        v.push_back('{2'd2, 32'h7FFF_FFFF, 5'd31});
        v.push_back('{2'd3, 32'h0000_0001, 5'd1});
        v.push_back('{2'd3, 32'h1234_5678, 5'd0});
        for (int i = 0; i < 10; i++)
            v.push_back('{2'($urandom_range(0, 3)), 32'($urandom), 5'($urandom_range(0, 31))});
        foreach (v[i]) begin
            issue(v[i].op, v[i].d, v[i].a);
            wait_valid(lat);
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL latency vec%0d: got %0d cycles, want %0d", i, lat, LAT);
            end
            e = sb.pop_front();
            checks++;
            if (out_data !== e.data) begin
                failures++;
                $display("FAIL data vec%0d op=%0d amt=%0d: got %h want %h", i, v[i].op, v[i].a, out_data, e.data);
            end
            checks++;
            if ({out_carry, out_zero} !== {e.carry, e.zero}) begin
                failures++;
                $display("FAIL flags vec%0d: got c=%b z=%b want c=%b z=%b", i, out_carry, out_zero, e.carry, e.zero);
            end
            handshake();
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                failures++;
                $display("FAIL post_hs vec%0d: got rdy=%b v=%b want rdy=1 v=0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        int   seen;
        issue(2'd1, 32'h8000_0001, 5'd1);
        wait_valid(lat);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1);
            in_op    = 2'd0;
            in_data  = 32'($urandom);
            in_amt   = 5'd3;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({out_valid, out_data, out_carry, out_zero} !== {1'b1, e.data, e.carry, e.zero}) begin
                failures++;
                $display("FAIL bp_hold cyc%0d: got v=%b d=%h c=%b z=%b want v=1 d=%h c=%b z=%b",
                         i, out_valid, out_data, out_carry, out_zero, e.data, e.carry, e.zero);
            end
        end
        in_valid = 1'b0;
        handshake();
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL bp_release: got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL bp_no_queue: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   lat;
        int   seen;
        issue(2'd0, 32'h0000_FFFF, 5'd5);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        void'(sb.pop_back());
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b010) begin
            failures++;
            $display("FAIL abort_shift: got busy=%b rdy=%b v=%b want busy=0 rdy=1 v=0", busy, in_ready, out_valid);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_resp: got %0d valid cycles want 0", seen);
        end
        // abort in IDLE blocks a concurrent request
        in_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b want 0", busy);
        end
        // abort while DONE drops the response
        issue(2'd3, 32'hA5A5_0001, 5'd7);
        wait_valid(lat);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        void'(sb.pop_back());
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL abort_done: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        issue(2'd0, 32'h0000_0003, 5'd2);
        wait_valid(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== LAT || out_data !== e.data || out_data !== 32'h0000_000C) begin
            failures++;
            $display("FAIL after_abort: got lat=%0d d=%h want lat=%0d d=%h", lat, out_data, LAT, e.data);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        issue(2'd1, 32'hDEAD_BEEF, 5'd9);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        checks++;
        if ({out_valid, out_data, out_carry, out_zero, in_ready, busy} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_shift: got v=%b d=%h c=%b z=%b rdy=%b busy=%b",
                     out_valid, out_data, out_carry, out_zero, in_ready, busy);
        end
        issue(2'd1, 32'h8000_0001, 5'd1);
        wait_valid(lat);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        checks++;
        if ({out_valid, out_data, out_carry, out_zero, in_ready, busy} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_done: got v=%b d=%h c=%b z=%b rdy=%b busy=%b",
                     out_valid, out_data, out_carry, out_zero, in_ready, busy);
        end
        issue(2'd2, 32'h8000_0000, 5'd4);
        wait_valid(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== LAT || {out_data, out_carry, out_zero} !== {e.data, e.carry, e.zero}) begin
            failures++;
            $display("FAIL after_reset: got lat=%0d d=%h c=%b want lat=%0d d=%h c=%b",
                     lat, out_data, out_carry, LAT, e.data, e.carry);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_shift_table();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
